musb_mem_arbiter: RTL and testbench

Three-master, single-slave arbiter that shares the SoC on-chip memory port between the bootloader loader, the core data port and the core instruction port. Sits in `musoc` between the masters and the memory; the core's `iport_*`/`dport_*` buses and the loader bus attach as masters. Fixed priority with an instruction-port anti-starvation override, plus a per-transaction timeout that returns a bus error.

---
 rtl/musb_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_musb_mem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/musb_mem_arbiter.sv
// musb_mem_arbiter
//   Shares one on-chip memory slave port between three masters:
//   m0 = bootloader loader, m1 = core data port, m2 = core instruction port.
//   Fixed priority m0 > m1 > m2. m2 is promoted once after STARVE_LIMIT
//   consecutive lost arbitrations. A granted transaction that waits TIMEOUT
//   cycles for the slave is terminated with a one-cycle error to its owner.
//
// Ports
//   clk, rst                      bus clock, synchronous active-high reset
//   mX_address/data_i/wr/enable   master requests (X = 0..2)
//   mX_data_o/ready/error         master responses, routed to the owner only
//   s_address/data_o/wr/enable    slave request, muxed from the owner
//   s_data_i/ready/error          slave response
//   grant                         one-hot registered owner, 0 when idle
module musb_mem_arbiter #(
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_wr,
    input  logic        m0_enable,
    output logic [31:0] m0_data_o,
    output logic        m0_ready,
    output logic        m0_error,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_wr,
    input  logic        m1_enable,
    output logic [31:0] m1_data_o,
    output logic        m1_ready,
    output logic        m1_error,
    input  logic [31:0] m2_address,
    input  logic [31:0] m2_data_i,
    input  logic [3:0]  m2_wr,
    input  logic        m2_enable,
    output logic [31:0] m2_data_o,
    output logic        m2_ready,
    output logic        m2_error,
    output logic [31:0] s_address,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_wr,
    output logic        s_enable,
    input  logic [31:0] s_data_i,
    input  logic        s_ready,
    input  logic        s_error,
    output logic [2:0]  grant
);

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);
    localparam logic [3:0] STV_LIM = 4'(STARVE_LIMIT);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [3:0]  starve_q, starve_d;

    logic        own_en;
    logic [31:0] own_addr;
    logic [31:0] own_data;
    logic [3:0]  own_wr;
    logic        timed_out;
    logic        rsp_rdy;
    logic        rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            tmo_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            tmo_q    <= tmo_d;
            starve_q <= starve_d;
        end
    end

    // Owner request mux; grant_q is zero in IDLE so everything falls to 0.
    always_comb begin
        own_en   = 1'b0;
        own_addr = '0;
        own_data = '0;
        own_wr   = '0;
        unique case (grant_q)
            3'b001: begin
                own_en = m0_enable; own_addr = m0_address; own_data = m0_data_i; own_wr = m0_wr;
            end
            3'b010: begin
                own_en = m1_enable; own_addr = m1_address; own_data = m1_data_i; own_wr = m1_wr;
            end
            3'b100: begin
                own_en = m2_enable; own_addr = m2_address; own_data = m2_data_i; own_wr = m2_wr;
            end
            default: ;
        endcase
    end

    always_comb begin
        timed_out = (state_q == BUSY) && (tmo_q == TMO_LIM);
        // Error dominates ready; a timed-out cycle never reports ready.
        rsp_err   = s_error | timed_out;
        rsp_rdy   = s_ready & ~rsp_err;

        s_address = own_addr;
        s_data_o  = own_data;
        s_wr      = own_wr;
        s_enable  = own_en & ~timed_out;

        m0_ready  = grant_q[0] & rsp_rdy;
        m1_ready  = grant_q[1] & rsp_rdy;
        m2_ready  = grant_q[2] & rsp_rdy;
        m0_error  = grant_q[0] & rsp_err;
        m1_error  = grant_q[1] & rsp_err;
        m2_error  = grant_q[2] & rsp_err;
        m0_data_o = grant_q[0] ? s_data_i : '0;
        m1_data_o = grant_q[1] ? s_data_i : '0;
        m2_data_o = grant_q[2] ? s_data_i : '0;
        grant     = grant_q;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        tmo_d    = tmo_q;
        starve_d = starve_q;
        unique case (state_q)
            IDLE: begin
                if (m0_enable || m1_enable || m2_enable) begin
                    state_d = BUSY;
                    tmo_d   = '0;
                    if (m2_enable && (starve_q == STV_LIM)) grant_d = 3'b100;
                    else if (m0_enable)                     grant_d = 3'b001;
                    else if (m1_enable)                     grant_d = 3'b010;
                    else                                    grant_d = 3'b100;

                    if (grant_d == 3'b100)
                        starve_d = '0;
                    else if (m2_enable && (starve_q != STV_LIM))
                        starve_d = starve_q + 4'd1;
                end
            end
            BUSY: begin
                if (s_ready || s_error || timed_out || !own_en) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_musb_mem_arbiter.sv
// tb_musb_mem_arbiter
//   Directed bench for musb_mem_arbiter with TIMEOUT=8, STARVE_LIMIT=4.
//   Inputs are driven 1ns after the rising edge, outputs checked on the
//   falling edge. Expected values are hand-computed per cycle.
module tb_musb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_address, m0_data_i, m0_data_o;
    logic [3:0]  m0_wr;
    logic        m0_enable, m0_ready, m0_error;
    logic [31:0] m1_address, m1_data_i, m1_data_o;
    logic [3:0]  m1_wr;
    logic        m1_enable, m1_ready, m1_error;
    logic [31:0] m2_address, m2_data_i, m2_data_o;
    logic [3:0]  m2_wr;
    logic        m2_enable, m2_ready, m2_error;
    logic [31:0] s_address, s_data_o, s_data_i;
    logic [3:0]  s_wr;
    logic        s_enable, s_ready, s_error;
    logic [2:0]  grant;

    logic        auto_rdy;
    logic        s_rdy_man;
    int unsigned vecs = 0;
    int unsigned errs = 0;

    // Zero-wait slave when auto_rdy is set, otherwise manually driven.
    assign s_ready = auto_rdy ? s_enable : s_rdy_man;

    always #5 clk = ~clk;

    musb_mem_arbiter #(.TIMEOUT(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_data_i(m0_data_i), .m0_wr(m0_wr), .m0_enable(m0_enable),
        .m0_data_o(m0_data_o), .m0_ready(m0_ready), .m0_error(m0_error),
        .m1_address(m1_address), .m1_data_i(m1_data_i), .m1_wr(m1_wr), .m1_enable(m1_enable),
        .m1_data_o(m1_data_o), .m1_ready(m1_ready), .m1_error(m1_error),
        .m2_address(m2_address), .m2_data_i(m2_data_i), .m2_wr(m2_wr), .m2_enable(m2_enable),
        .m2_data_o(m2_data_o), .m2_ready(m2_ready), .m2_error(m2_error),
        .s_address(s_address), .s_data_o(s_data_o), .s_wr(s_wr), .s_enable(s_enable),
        .s_data_i(s_data_i), .s_ready(s_ready), .s_error(s_error),
        .grant(grant)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        m0_address = '0; m0_data_i = '0; m0_wr = '0; m0_enable = 1'b0;
        m1_address = '0; m1_data_i = '0; m1_wr = '0; m1_enable = 1'b0;
        m2_address = '0; m2_data_i = '0; m2_wr = '0; m2_enable = 1'b0;
        s_data_i = '0; s_rdy_man = 1'b0; s_error = 1'b0; auto_rdy = 1'b0;

        // Reset state
        nxt(); nxt(); smp();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_s_enable", 32'(s_enable), 0);
        chk("rst_starve", 32'(dut.starve_q), 0);
        nxt(); rst = 1'b0;

        // Single iport read, slave answers one cycle after grant
        nxt(); m2_address = 32'h100; m2_enable = 1'b1;
        smp(); chk("t1_idle_grant", 32'(grant), 0);
        nxt(); smp();
        chk("t1_grant", 32'(grant), 32'b100);
        chk("t1_s_enable", 32'(s_enable), 1);
        chk("t1_s_addr", s_address, 32'h100);
        chk("t1_wait_ready", 32'(m2_ready), 0);
        nxt(); s_rdy_man = 1'b1; s_data_i = 32'hDEADBEEF;
        smp();
        chk("t1_ready", 32'(m2_ready), 1);
        chk("t1_data", m2_data_o, 32'hDEADBEEF);
        chk("t1_m0_data", m0_data_o, 0);
        nxt(); s_rdy_man = 1'b0; m2_enable = 1'b0;
        smp(); chk("t1_release", 32'(grant), 0);

        // Simultaneous requests, zero-wait slave
        auto_rdy = 1'b1;
        nxt(); m0_enable = 1'b1; m1_enable = 1'b1; m2_enable = 1'b1;
        smp(); chk("t2_idle", 32'(grant), 0);
        nxt(); smp();
        chk("t2_g0", 32'(grant), 32'b001);
        chk("t2_m0_rdy", 32'(m0_ready), 1);
        chk("t2_m1_nordy", 32'(m1_ready), 0);
        chk("t2_stv1", 32'(dut.starve_q), 1);
        nxt(); m0_enable = 1'b0;
        smp(); chk("t2_gap0", 32'(grant), 0);
        nxt(); smp();
        chk("t2_g1", 32'(grant), 32'b010);
        chk("t2_m1_rdy", 32'(m1_ready), 1);
        chk("t2_stv2", 32'(dut.starve_q), 2);
        nxt(); m1_enable = 1'b0;
        smp(); chk("t2_gap1", 32'(grant), 0);
        nxt(); smp();
        chk("t2_g2", 32'(grant), 32'b100);
        chk("t2_m2_rdy", 32'(m2_ready), 1);
        chk("t2_stv0", 32'(dut.starve_q), 0);
        nxt(); m2_enable = 1'b0;
        smp(); chk("t2_end", 32'(grant), 0);

        // Starvation: m1 re-requests forever, m2 pending
        nxt(); m1_enable = 1'b1; m2_enable = 1'b1;
        smp();
        for (int i = 1; i <= 9; i++) begin
            logic [2:0] eg;
            logic [3:0] es;
            nxt(); smp();
            eg = (i == 9) ? 3'b100 : ((i % 2) == 1) ? 3'b010 : 3'b000;
            es = (i == 9) ? 4'd0 : 4'((i + 1) / 2);
            chk($sformatf("t3_grant_%0d", i), 32'(grant), 32'(eg));
            chk($sformatf("t3_stv_%0d", i), 32'(dut.starve_q), 32'(es));
        end
        nxt(); m2_enable = 1'b0;
        smp(); chk("t3_gap", 32'(grant), 0);
        nxt(); smp();
        chk("t3_m1_again", 32'(grant), 32'b010);
        chk("t3_stv_hold", 32'(dut.starve_q), 0);
        nxt(); m1_enable = 1'b0; auto_rdy = 1'b0;
        smp(); chk("t3_end", 32'(grant), 0);

        // Timeout with a slave that never answers
        nxt(); m1_address = 32'h200; m1_wr = 4'hF; m1_data_i = 32'h0BADF00D; m1_enable = 1'b1;
        smp();
        for (int i = 0; i <= 8; i++) begin
            nxt(); smp();
            chk($sformatf("t4_grant_%0d", i), 32'(grant), 32'b010);
            chk($sformatf("t4_err_%0d", i), 32'(m1_error), (i == 8) ? 1 : 0);
            chk($sformatf("t4_sen_%0d", i), 32'(s_enable), (i == 8) ? 0 : 1);
            chk($sformatf("t4_rdy_%0d", i), 32'(m1_ready), 0);
        end
        chk("t4_s_wr", 32'(s_wr), 32'hF);
        chk("t4_s_data", s_data_o, 32'h0BADF00D);
        nxt(); m1_enable = 1'b0; m1_wr = '0;
        smp();
        chk("t4_idle", 32'(grant), 0);
        chk("t4_err_gone", 32'(m1_error), 0);

        // Abort: owner drops enable while waiting
        nxt(); m0_address = 32'h300; m0_enable = 1'b1;
        smp();
        nxt(); smp(); chk("t5_grant", 32'(grant), 32'b001);
        nxt(); smp(); chk("t5_wait", 32'(m0_ready), 0);
        nxt(); m0_enable = 1'b0;
        smp();
        chk("t5_abort_sen", 32'(s_enable), 0);
        chk("t5_abort_rdy", 32'(m0_ready), 0);
        chk("t5_abort_err", 32'(m0_error), 0);
        nxt(); smp(); chk("t5_abort_idle", 32'(grant), 0);

        // Ready and error together: error wins
        nxt(); m1_enable = 1'b1;
        smp();
        nxt(); s_rdy_man = 1'b1; s_error = 1'b1;
        smp();
        chk("t5_both_grant", 32'(grant), 32'b010);
        chk("t5_both_err", 32'(m1_error), 1);
        chk("t5_both_rdy", 32'(m1_ready), 0);
        chk("t5_nonowner_err", 32'(m0_error), 0);
        nxt(); m1_enable = 1'b0; s_rdy_man = 1'b0; s_error = 1'b0;
        smp(); chk("t5_both_idle", 32'(grant), 0);

        // Reset in the middle of a transaction
        nxt(); m1_enable = 1'b1; m2_enable = 1'b1; s_data_i = 32'hA5A5A5A5;
        smp();
        nxt(); smp();
        chk("t6_grant", 32'(grant), 32'b010);
        chk("t6_stv", 32'(dut.starve_q), 1);
        nxt(); nxt(); smp();
        chk("t6_tmo", 32'(dut.tmo_q), 2);
        nxt(); rst = 1'b1;
        smp();
        nxt(); rst = 1'b0;
        smp();
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_sen", 32'(s_enable), 0);
        chk("t6_rst_saddr", s_address, 0);
        chk("t6_rst_swr", 32'(s_wr), 0);
        chk("t6_rst_data", m1_data_o, 0);
        chk("t6_rst_stv", 32'(dut.starve_q), 0);
        chk("t6_rst_tmo", 32'(dut.tmo_q), 0);
        nxt(); smp();
        chk("t6_regrant", 32'(grant), 32'b010);
        chk("t6_regrant_sen", 32'(s_enable), 1);
        chk("t6_regrant_stv", 32'(dut.starve_q), 1);
        nxt(); m1_enable = 1'b0; m2_enable = 1'b0;
        smp();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
